// File: rtl/chunk_feeder_pkg.sv
// Shared types and constants for the chunk message feeder.
package chunk_feeder_pkg;

  typedef enum logic [1:0] {IDLE, FILL, RUN, DBL} feeder_state_t;

  localparam int BLK_BYTES  = 64;
  localparam int BLK_WORDS  = 16;
  localparam int DBL_BYTES  = 32;
  localparam int HASH_WORDS = 8;

  // Byte-valid mask for message word word_idx of a len-byte message.
  // Bit b is set when byte (4*word_idx + b) lies inside the message.
  function automatic logic [3:0] byte_mask(input logic [10:0] len,
                                           input logic [10:0] word_idx);
    logic [12:0] base;
    logic [3:0]  m;
    base = {word_idx, 2'b00};
    for (int b = 0; b < 4; b++) begin
      m[b] = ((base + 13'(b)) < {2'b00, len});
    end
    return m;
  endfunction

endpackage

// File: rtl/msg_block_buf.sv
// Ping-pong block store: two 16-word buffers with full flags and
// independent write / read selects.
module msg_block_buf
  import chunk_feeder_pkg::*;
#(
  parameter int WORDS = BLK_WORDS,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [31:0]           wr_data,
  input  logic                  wr_last,
  input  logic                  rd_adv,
  output logic [WORDS-1:0][31:0] rd_data,
  output logic [1:0]            full,
  output logic                  wr_sel,
  output logic                  rd_sel
);

  logic [1:0][WORDS-1:0][31:0] mem_q;
  logic [1:0]                  full_q, full_d;
  logic                        wr_sel_q, wr_sel_d;
  logic                        rd_sel_q, rd_sel_d;

  // Next flags/selects: a completing write and a read release touch
  // different buffers, so both are applied in the same cycle.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    if (clr) begin
      full_d   = '0;
      wr_sel_d = 1'b0;
      rd_sel_d = 1'b0;
    end else begin
      if (wr_en && wr_last) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
      end
      if (rd_adv) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  // Storage; the first word of a block wipes the rest so a short final
  // block leaves zeros behind its last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (wr_en && !clr) begin
      if (wr_idx == '0) begin
        mem_q[wr_sel_q] <= '0;
      end
      mem_q[wr_sel_q][wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_sel_q];
  assign full    = full_q;
  assign wr_sel  = wr_sel_q;
  assign rd_sel  = rd_sel_q;

endmodule

// File: rtl/chunk_msg_feeder.sv
// Producer side of the ChunkHasher message interface: packs a word
// stream into 64-byte blocks, feeds them to the hasher, then feeds the
// first-pass hash back as a 32-byte second-pass message.
module chunk_msg_feeder #(
  parameter int MAX_BYTES = 1024,
  parameter int BLK_WORDS = 16
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      Start_I,
  input  logic [10:0]               Len_I,
  input  logic [31:0]               Din_I,
  input  logic                      Din_Vld_I,
  output logic                      Din_Rdy_O,
  output logic [BLK_WORDS-1:0][31:0] Msg_O,
  output logic                      Update_O,
  output logic                      DblUpdate_O,
  output logic [10:0]               Byte_num_O,
  input  logic                      Next_I,
  input  logic [7:0][31:0]          H_I,
  input  logic                      Vld_I,
  output logic                      Clear_O,
  output logic [7:0][31:0]          Hash_O,
  output logic                      Hash_Vld_O,
  output logic                      Busy_O,
  output logic                      Underrun_O
);

  import chunk_feeder_pkg::*;

  localparam int IDX_W = $clog2(BLK_WORDS);

  feeder_state_t state_q, state_d;

  logic [10:0]                  len_q;
  logic [8:0]                   wr_cnt_q;
  logic [4:0]                   blk_cnt_q;
  logic                         underrun_q;
  logic                         dbl_first_q;
  logic [HASH_WORDS-1:0][31:0]  hcap_q;
  logic [7:0][31:0]             hash_q;
  logic                         hash_vld_q;

  logic [8:0]                   total_words;
  logic [4:0]                   total_blocks;
  logic [10:0]                  len_eff;
  logic                         len_bad;
  logic [3:0]                   mask;
  logic [31:0]                  wr_data;
  logic                         hs;
  logic                         wr_last;
  logic                         start_acc;
  logic                         rd_adv;
  logic                         last_done;
  logic                         new_full;
  logic                         more_blocks;
  logic                         underrun_hit;
  logic                         dbl_vld;

  logic [BLK_WORDS-1:0][31:0]   buf_rd_data;
  logic [1:0]                   buf_full;
  logic                         buf_wr_sel;
  logic                         buf_rd_sel;

  assign total_words  = 9'((len_q + 11'd3) >> 2);
  assign total_blocks = 5'((len_q + 11'(BLK_BYTES - 1)) >> $clog2(BLK_BYTES));

  assign len_bad = (Len_I == 11'd0) || (Len_I > 11'(MAX_BYTES));
  assign len_eff = (Len_I == 11'd0)        ? 11'd1 :
                   (Len_I > 11'(MAX_BYTES)) ? 11'(MAX_BYTES) : Len_I;

  assign mask    = byte_mask(len_q, {2'b00, wr_cnt_q});
  assign wr_data = Din_I & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  assign hs      = Din_Vld_I && Din_Rdy_O;
  assign wr_last = (wr_cnt_q[IDX_W-1:0] == IDX_W'(BLK_WORDS - 1)) ||
                   (wr_cnt_q == total_words - 9'd1);

  assign start_acc = (state_q == IDLE) && Start_I;
  assign rd_adv    = (state_q == RUN) && Next_I;
  assign last_done = rd_adv && Vld_I;

  // The buffer about to be presented counts as full if its last word is
  // being written in this very cycle.
  assign new_full     = buf_full[~buf_rd_sel] ||
                        (hs && wr_last && (buf_wr_sel != buf_rd_sel));
  assign more_blocks  = (blk_cnt_q + 5'd1) < total_blocks;
  assign underrun_hit = rd_adv && !Vld_I && more_blocks && !new_full;
  assign dbl_vld      = (state_q == DBL) && !dbl_first_q && Vld_I;

  msg_block_buf #(
    .WORDS (BLK_WORDS)
  ) u_buf (
    .clk     (Clk),
    .rst     (Rst),
    .clr     (start_acc),
    .wr_en   (hs),
    .wr_idx  (wr_cnt_q[IDX_W-1:0]),
    .wr_data (wr_data),
    .wr_last (wr_last),
    .rd_adv  (rd_adv),
    .rd_data (buf_rd_data),
    .full    (buf_full),
    .wr_sel  (buf_wr_sel),
    .rd_sel  (buf_rd_sel)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (Start_I) state_d = FILL;
      FILL: if (buf_full[0]) state_d = RUN;
      RUN: begin
        if (last_done)         state_d = DBL;
        else if (underrun_hit) state_d = IDLE;
      end
      DBL: if (dbl_vld) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: length, counters, error flag and hash captures.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      len_q       <= '0;
      wr_cnt_q    <= '0;
      blk_cnt_q   <= '0;
      underrun_q  <= 1'b0;
      dbl_first_q <= 1'b0;
      hcap_q      <= '0;
      hash_q      <= '0;
      hash_vld_q  <= 1'b0;
    end else begin
      dbl_first_q <= 1'b0;
      hash_vld_q  <= 1'b0;
      if (start_acc) begin
        len_q      <= len_eff;
        underrun_q <= len_bad;
        wr_cnt_q   <= '0;
        blk_cnt_q  <= '0;
      end
      if (hs)           wr_cnt_q   <= wr_cnt_q + 9'd1;
      if (rd_adv)       blk_cnt_q  <= blk_cnt_q + 5'd1;
      if (underrun_hit) underrun_q <= 1'b1;
      if (last_done) begin
        hcap_q      <= H_I;
        dbl_first_q <= 1'b1;
      end
      if (dbl_vld) begin
        hash_q     <= H_I;
        hash_vld_q <= 1'b1;
      end
    end
  end

  // Outputs decoded from state and registered datapath.
  always_comb begin
    Din_Rdy_O   = 1'b0;
    Update_O    = 1'b0;
    DblUpdate_O = 1'b0;
    Byte_num_O  = '0;
    Clear_O     = underrun_hit;
    Msg_O       = buf_rd_data;
    Busy_O      = (state_q != IDLE);
    case (state_q)
      FILL: begin
        Din_Rdy_O = !buf_full[buf_wr_sel] && (wr_cnt_q < total_words);
        Update_O  = buf_full[0];
        if (buf_full[0]) Byte_num_O = len_q;
      end
      RUN: begin
        Din_Rdy_O  = !buf_full[buf_wr_sel] && (wr_cnt_q < total_words);
        Byte_num_O = len_q;
      end
      DBL: begin
        DblUpdate_O = dbl_first_q;
        Byte_num_O  = 11'(DBL_BYTES);
        Msg_O       = '0;
        Msg_O[HASH_WORDS-1:0] = hcap_q;
      end
      default: ;
    endcase
  end

  assign Hash_O     = hash_q;
  assign Hash_Vld_O = hash_vld_q;
  assign Underrun_O = underrun_q;

endmodule

// File: tb/tb_chunk_msg_feeder.sv
// Directed self-checking bench for chunk_msg_feeder.
module tb_chunk_msg_feeder;

  logic              Clk;
  logic              Rst;
  logic              Start_I;
  logic [10:0]       Len_I;
  logic [31:0]       Din_I;
  logic              Din_Vld_I;
  logic              Din_Rdy_O;
  logic [15:0][31:0] Msg_O;
  logic              Update_O;
  logic              DblUpdate_O;
  logic [10:0]       Byte_num_O;
  logic              Next_I;
  logic [7:0][31:0]  H_I;
  logic              Vld_I;
  logic              Clear_O;
  logic [7:0][31:0]  Hash_O;
  logic              Hash_Vld_O;
  logic              Busy_O;
  logic              Underrun_O;

  int checks = 0;
  int fails  = 0;
  int stalls = 0;

  typedef struct {
    logic [10:0] len;
    logic [31:0] base;
    logic [31:0] stride;
    int          tw;
    logic [31:0] lastWord;
    logic [10:0] byteNum;
    logic        underrun;
  } vec_t;

  vec_t vecs[8];

  chunk_msg_feeder dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Start_I     (Start_I),
    .Len_I       (Len_I),
    .Din_I       (Din_I),
    .Din_Vld_I   (Din_Vld_I),
    .Din_Rdy_O   (Din_Rdy_O),
    .Msg_O       (Msg_O),
    .Update_O    (Update_O),
    .DblUpdate_O (DblUpdate_O),
    .Byte_num_O  (Byte_num_O),
    .Next_I      (Next_I),
    .H_I         (H_I),
    .Vld_I       (Vld_I),
    .Clear_O     (Clear_O),
    .Hash_O      (Hash_O),
    .Hash_Vld_O  (Hash_Vld_O),
    .Busy_O      (Busy_O),
    .Underrun_O  (Underrun_O)
  );

  // Free-running 100 MHz clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Hard stop in case something hangs.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, failures so far %0d", fails);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic startMsg(input logic [10:0] len);
    Start_I = 1'b1;
    Len_I   = len;
    step();
    Start_I = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] d);
    int n;
    n = 0;
    Din_I     = d;
    Din_Vld_I = 1'b1;
    while (!Din_Rdy_O && n < 500) begin
      stalls++;
      step();
      n++;
    end
    if (!Din_Rdy_O) checkOutput("din_rdy_timeout", {511'b0, Din_Rdy_O}, 512'd1);
    step();
    Din_Vld_I = 1'b0;
  endtask

  function automatic logic [15:0][31:0] dblMsg(input logic [7:0][31:0] h);
    logic [15:0][31:0] e;
    e = '0;
    e[7:0] = h;
    return e;
  endfunction

  // Last block with result, then second pass and final hash.
  task automatic finishHash(input logic [7:0][31:0] h1, input logic [7:0][31:0] h2);
    Next_I = 1'b1;
    Vld_I  = 1'b1;
    H_I    = h1;
    #1;
    checkOutput("clear_last", Clear_O, 0);
    step();
    Next_I = 1'b0;
    Vld_I  = 1'b0;
    H_I    = '0;
    checkOutput("dbl_update", DblUpdate_O, 1);
    checkOutput("dbl_bytenum", Byte_num_O, 32);
    checkOutput("dbl_msg", Msg_O, dblMsg(h1));
    step();
    checkOutput("dbl_update_width", DblUpdate_O, 0);
    repeat (3) step();
    checkOutput("hash_vld_early", Hash_Vld_O, 0);
    Vld_I = 1'b1;
    H_I   = h2;
    step();
    Vld_I = 1'b0;
    H_I   = '0;
    checkOutput("hash_vld", Hash_Vld_O, 1);
    checkOutput("hash_val", Hash_O, h2);
    checkOutput("busy_done", Busy_O, 0);
    step();
    checkOutput("hash_vld_width", Hash_Vld_O, 0);
    checkOutput("hash_hold", Hash_O, h2);
  endtask

  // Single-block message from a table record, run to completion.
  task automatic applyStimulus(input vec_t v, input int id);
    logic [15:0][31:0] e;
    logic [7:0][31:0]  h1, h2;
    for (int k = 0; k < 8; k++) begin
      h1[k] = 32'hAAAA0000 | 32'(id << 8) | 32'(k);
      h2[k] = 32'h55550000 | 32'(id << 8) | 32'(k);
    end
    startMsg(v.len);
    checkOutput("busy_fill", Busy_O, 1);
    checkOutput("underrun_start", Underrun_O, v.underrun);
    for (int i = 0; i < v.tw; i++) begin
      if (i == v.tw - 1) checkOutput("update_early", Update_O, 0);
      sendWord(v.base + v.stride * 32'(i));
    end
    for (int i = 0; i < 16; i++) begin
      if (i < v.tw - 1)       e[i] = v.base + v.stride * 32'(i);
      else if (i == v.tw - 1) e[i] = v.lastWord;
      else                    e[i] = 32'h0;
    end
    checkOutput("update_pulse", Update_O, 1);
    checkOutput("bytenum", Byte_num_O, v.byteNum);
    checkOutput("msg_block", Msg_O, e);
    step();
    checkOutput("update_width", Update_O, 0);
    checkOutput("din_rdy_done", Din_Rdy_O, 0);
    finishHash(h1, h2);
  endtask

  initial begin
    logic [15:0][31:0] e;
    logic [7:0][31:0]  ha, hb;

    vecs[0] = '{11'd64, 32'h00000000, 32'h00000001, 16, 32'h0000000F, 11'd64, 1'b0};
    vecs[1] = '{11'd5,  32'h44332211, 32'h9A7A9CDE, 2,  32'h000000EF, 11'd5,  1'b0};
    vecs[2] = '{11'd1,  32'hCAFEBABE, 32'h00000000, 1,  32'h000000BE, 11'd1,  1'b0};
    vecs[3] = '{11'd7,  32'h11223344, 32'h01010101, 2,  32'h00233445, 11'd7,  1'b0};
    vecs[4] = '{11'd62, 32'hA0000000, 32'h00000100, 16, 32'h00000F00, 11'd62, 1'b0};
    vecs[5] = '{11'd33, 32'hFFFFFFFF, 32'h00000000, 9,  32'h000000FF, 11'd33, 1'b0};
    vecs[6] = '{11'd0,  32'h12345678, 32'h00000000, 1,  32'h00000078, 11'd1,  1'b1};
    vecs[7] = '{11'd4,  32'h89ABCDEF, 32'h00000000, 1,  32'h89ABCDEF, 11'd4,  1'b0};

    Rst = 1'b1; Start_I = 1'b0; Len_I = '0; Din_I = '0; Din_Vld_I = 1'b0;
    Next_I = 1'b0; Vld_I = 1'b0; H_I = '0;
    repeat (2) step();
    checkOutput("rst_busy", Busy_O, 0);
    checkOutput("rst_din_rdy", Din_Rdy_O, 0);
    checkOutput("rst_update", Update_O, 0);
    checkOutput("rst_msg", Msg_O, 0);
    checkOutput("rst_hash", Hash_O, 0);
    checkOutput("rst_bytenum", Byte_num_O, 0);
    checkOutput("rst_underrun", Underrun_O, 0);
    Rst = 1'b0;
    step();

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v], v);
      step();
    end

    // Underrun: 200-byte message, source stops after 20 words.
    startMsg(11'd200);
    for (int i = 0; i < 20; i++) sendWord(32'h100 + 32'(i));
    repeat (2) step();
    for (int i = 0; i < 16; i++) e[i] = 32'h100 + 32'(i);
    checkOutput("ur_busy_run", Busy_O, 1);
    checkOutput("ur_block0", Msg_O, e);
    Next_I = 1'b1;
    #1;
    checkOutput("ur_clear", Clear_O, 1);
    step();
    Next_I = 1'b0;
    checkOutput("ur_flag", Underrun_O, 1);
    checkOutput("ur_busy", Busy_O, 0);
    checkOutput("ur_din_rdy", Din_Rdy_O, 0);
    checkOutput("ur_clear_width", Clear_O, 0);
    step();

    // Start ignored in RUN, then reset mid-RUN.
    startMsg(11'd0);
    checkOutput("len0_underrun", Underrun_O, 1);
    sendWord(32'h12345678);
    step();
    Start_I = 1'b1;
    Len_I   = 11'd64;
    step();
    Start_I = 1'b0;
    checkOutput("start_ign_busy", Busy_O, 1);
    checkOutput("start_ign_bytenum", Byte_num_O, 1);
    checkOutput("start_ign_underrun", Underrun_O, 1);
    Rst = 1'b1;
    step();
    checkOutput("mrst_busy", Busy_O, 0);
    checkOutput("mrst_din_rdy", Din_Rdy_O, 0);
    checkOutput("mrst_underrun", Underrun_O, 0);
    checkOutput("mrst_msg", Msg_O, 0);
    checkOutput("mrst_bytenum", Byte_num_O, 0);
    checkOutput("mrst_hash", Hash_O, 0);
    checkOutput("mrst_update", Update_O, 0);
    Rst = 1'b0;
    step();
    applyStimulus(vecs[0], 9);
    step();

    // 16th word of buffer 1 lands in the same cycle as Next_I.
    startMsg(11'd128);
    for (int i = 0; i < 31; i++) sendWord(32'h2000 + 32'(i));
    Din_I     = 32'h2000 + 32'd31;
    Din_Vld_I = 1'b1;
    Next_I    = 1'b1;
    #1;
    checkOutput("sim_din_rdy", Din_Rdy_O, 1);
    checkOutput("sim_clear", Clear_O, 0);
    step();
    Din_Vld_I = 1'b0;
    Next_I    = 1'b0;
    for (int i = 0; i < 16; i++) e[i] = 32'h2000 + 32'(16 + i);
    checkOutput("sim_underrun", Underrun_O, 0);
    checkOutput("sim_busy", Busy_O, 1);
    checkOutput("sim_block1", Msg_O, e);
    for (int k = 0; k < 8; k++) begin
      ha[k] = 32'hAAAAAAAA;
      hb[k] = 32'h55555555;
    end
    finishHash(ha, hb);
    step();

    // 1024-byte message at full source rate, Next every 72 cycles.
    stalls = 0;
    startMsg(11'd1024);
    fork
      begin
        for (int i = 0; i < 256; i++) sendWord(32'(i));
      end
      begin
        int n;
        logic [15:0][31:0] eb;
        logic [7:0][31:0]  h1, h2;
        n = 0;
        while (!Update_O && n < 1000) begin
          step();
          n++;
        end
        checkOutput("big_update", Update_O, 1);
        for (int b = 0; b < 16; b++) begin
          repeat (72) step();
          for (int i = 0; i < 16; i++) eb[i] = 32'(b * 16 + i);
          checkOutput("big_block", Msg_O, eb);
          checkOutput("big_bytenum", Byte_num_O, 1024);
          checkOutput("big_underrun", Underrun_O, 0);
          if (b < 15) begin
            Next_I = 1'b1;
            #1;
            checkOutput("big_clear", Clear_O, 0);
            step();
            Next_I = 1'b0;
          end else begin
            for (int k = 0; k < 8; k++) begin
              h1[k] = 32'hA5A50000 | 32'(k);
              h2[k] = 32'h5A5A0000 | 32'(k);
            end
            finishHash(h1, h2);
          end
        end
      end
    join
    checkOutput("big_stalled", {511'b0, (stalls > 0)}, 512'd1);
    checkOutput("big_underrun_end", Underrun_O, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
